seq_mult_param: RTL and testbench

//   Parametrised sequential add-shift multiplier; next generation of the 8-bit lab multiplier.

---
 rtl/seq_mult_param.sv | 110 +++++++++++
 tb/tb_seq_mult_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Sequential add-shift multiplier with WIDTH-bit operands and a 2*WIDTH-bit product.
// Signed or unsigned operation is selected at run time and latched when an operation starts.
// Start/Busy/Done handshake: one multiplication per Start press, and the result is held until the next start.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Signed_Mode,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 Busy,
  output logic                 Done,
  output logic                 X,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic             x;
  logic             mode;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic             sub;

  // Extend both operands to WIDTH+1 bits. Sign extension is used in signed mode and zero
  // extension otherwise. Bit WIDTH of the result is the true sign (signed) or the carry
  // (unsigned), and it lands in X.
  function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] acc,
                                             input logic [WIDTH-1:0] mc,
                                             input logic             sgn,
                                             input logic             do_sub);
    logic signed [WIDTH:0] ea;
    logic signed [WIDTH:0] em;
    ea = $signed({sgn & acc[WIDTH-1], acc});
    em = $signed({sgn & mc[WIDTH-1], mc});
    return do_sub ? logic'(1'b0) ? '0 : $unsigned(ea - em) : $unsigned(ea + em);
  endfunction

  // The multiplier MSB has negative weight in two's complement, so that last partial product is subtracted.
  assign sub = mode && (cnt == CNT_LAST);
  assign sum = add_sub(a, m, mode, sub);

  // FSM and datapath registers; reset clears everything and aborts any operation in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      a     <= '0;
      b     <= '0;
      m     <= '0;
      x     <= 1'b0;
      mode  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            a     <= '0;
            x     <= 1'b0;
            b     <= Multiplier;
            m     <= Multiplicand;
            mode  <= Signed_Mode;
            cnt   <= '0;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          if (b[0]) begin
            {x, a} <= sum;
          end
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          // Signed: arithmetic shift, so X keeps the sign. Unsigned: the carry in X shifts into A and X clears.
          a   <= {x, a[WIDTH-1:1]};
          b   <= {a[0], b[WIDTH-1:1]};
          if (!mode) begin
            x <= 1'b0;
          end
          cnt <= cnt + CNT_W'(1);
          state <= (cnt == CNT_LAST) ? S_HOLD : S_ADD;
        end
        S_HOLD: begin
          // Wait for Start to be released so that one press yields exactly one operation.
          if (!Start) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Busy    = (state == S_ADD) || (state == S_SHIFT);
  assign Done    = (state == S_HOLD);
  assign X       = x;
  assign Product = {a, b};

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param. A scoreboard holds one WIDTH=8 and one WIDTH=16 instance.
// The driver pushes the expected products into queues, and the monitors pop and compare
// them whenever Done rises.
module tb_seq_mult_param;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  mc8 = '0, mp8 = '0;
  logic        busy8, done8, x8;
  logic [15:0] prod8;

  logic        start16 = 1'b0, sgn16 = 1'b0;
  logic [15:0] mc16 = '0, mp16 = '0;
  logic        busy16, done16, x16;
  logic [31:0] prod16;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q8[$];
  logic [31:0] q16[$];

  always #5 Clk = ~Clk;

  seq_mult_param #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Start(start8), .Signed_Mode(sgn8),
    .Multiplicand(mc8), .Multiplier(mp8),
    .Busy(busy8), .Done(done8), .X(x8), .Product(prod8)
  );

  seq_mult_param #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .Start(start16), .Signed_Mode(sgn16),
    .Multiplicand(mc16), .Multiplier(mp16),
    .Busy(busy16), .Done(done16), .X(x16), .Product(prod16)
  );

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input bit sgn, input bit w16);
    logic signed [31:0] sa, sb, sp;
    logic [31:0] p;
    if (w16) begin
      if (sgn) begin
        sa = $signed(a); sb = $signed(b); sp = sa * sb; p = sp;
      end else begin
        p = {16'h0, a} * {16'h0, b};
      end
    end else begin
      if (sgn) begin
        sa = $signed(a[7:0]); sb = $signed(b[7:0]); sp = sa * sb; p = {16'h0, sp[15:0]};
      end else begin
        p = {16'h0, ({8'h0, a[7:0]} * {8'h0, b[7:0]})};
      end
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor for the 8-bit instance.
  initial begin
    bit prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (done8 && !prev) begin
        n_checks++;
        if (q8.size() == 0) begin
          n_fail++;
          $display("FAIL sb8_unexpected: got %h, expected no result", prod8);
        end else begin
          e = q8.pop_front();
          if (prod8 !== e) begin
            n_fail++;
            $display("FAIL sb8_product: got %h, expected %h", prod8, e);
          end
        end
      end
      prev = done8;
    end
  end

  // Monitor for the 16-bit instance.
  initial begin
    bit prev;
    logic [31:0] e;
    prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (done16 && !prev) begin
        n_checks++;
        if (q16.size() == 0) begin
          n_fail++;
          $display("FAIL sb16_unexpected: got %h, expected no result", prod16);
        end else begin
          e = q16.pop_front();
          if (prod16 !== e) begin
            n_fail++;
            $display("FAIL sb16_product: got %h, expected %h", prod16, e);
          end
        end
      end
      prev = done16;
    end
  end

  // Issue one operation, push its expected product, and check Busy/Done timing edge by edge.
  // The operand inputs are scrambled while Busy to confirm that they are ignored.
  task automatic run_op(input bit w16, input logic [15:0] mc, input logic [15:0] mp,
                        input bit sgn, input logic [31:0] expv, input bit hold);
    int n;
    bit ok;
    logic b, d;
    n = w16 ? 32 : 16;
    @(negedge Clk);
    if (w16) begin
      mc16 = mc; mp16 = mp; sgn16 = sgn; start16 = 1'b1; q16.push_back(expv);
    end else begin
      mc8 = mc[7:0]; mp8 = mp[7:0]; sgn8 = sgn; start8 = 1'b1; q8.push_back(expv[15:0]);
    end
    @(posedge Clk);
    #1;
    if (!hold) begin
      start8 = 1'b0; start16 = 1'b0;
    end
    ok = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge Clk);
      #1;
      if (k == 1) begin
        mc8 = 8'($urandom); mp8 = 8'($urandom); sgn8 = ~sgn8;
        mc16 = 16'($urandom); mp16 = 16'($urandom); sgn16 = ~sgn16;
      end
      b = w16 ? busy16 : busy8;
      d = w16 ? done16 : done8;
      if (b !== (k < n) || d !== (k == n)) ok = 1'b0;
    end
    check(w16 ? "latency16" : "latency8", {31'h0, ok}, 32'h1);
    if (!hold) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    bit rs;
    int guard;

    repeat (3) @(posedge Clk);
    #1;
    check("rst_product8", {16'h0, prod8}, 32'h0);
    check("rst_flags8", {29'h0, busy8, done8, x8}, 32'h0);
    check("rst_product16", prod16, 32'h0);
    check("rst_flags16", {29'h0, busy16, done16, x16}, 32'h0);
    Reset = 1'b0;

    // Directed vectors, WIDTH=8
    run_op(1'b0, 16'h07, 16'hC5, 1'b1, 32'h0000FE63, 1'b0);
    run_op(1'b0, 16'h80, 16'h80, 1'b1, 32'h00004000, 1'b0);
    run_op(1'b0, 16'hFF, 16'h01, 1'b1, 32'h0000FFFF, 1'b0);
    run_op(1'b0, 16'h00, 16'h9A, 1'b1, 32'h00000000, 1'b0);
    run_op(1'b0, 16'h7F, 16'h81, 1'b1, 32'h0000C0FF, 1'b0);
    run_op(1'b0, 16'h80, 16'h02, 1'b0, 32'h00000100, 1'b0);
    run_op(1'b0, 16'h0D, 16'h0B, 1'b0, 32'h0000008F, 1'b0);

    // Start held through HOLD: a single operation, Done stays high until Start drops
    run_op(1'b0, 16'hFF, 16'hFF, 1'b0, 32'h0000FE01, 1'b1);
    repeat (24) @(posedge Clk);
    #1;
    check("hold_done", {30'h0, busy8, done8}, 32'h1);
    check("hold_product", {16'h0, prod8}, 32'h0000FE01);
    start8 = 1'b0;
    @(posedge Clk);
    #1;
    check("release_idle", {30'h0, busy8, done8}, 32'h0);
    check("release_product", {16'h0, prod8}, 32'h0000FE01);

    // Reset sampled at edge 5 of an operation
    @(negedge Clk);
    mc8 = 8'h07; mp8 = 8'hC5; sgn8 = 1'b1; start8 = 1'b1;
    @(posedge Clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("busy_before_reset", {31'h0, busy8}, 32'h1);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("abort_product", {16'h0, prod8}, 32'h0);
    check("abort_flags", {29'h0, busy8, done8, x8}, 32'h0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("abort_stays_idle", {30'h0, busy8, done8}, 32'h0);

    // Directed vectors, WIDTH=16
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0);
    run_op(1'b1, 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 1'b0);
    run_op(1'b1, 16'h1234, 16'h0010, 1'b0, 32'h00012340, 1'b0);
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0);
    run_op(1'b1, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      run_op(1'b1, ra, rb, rs, ref_mul(ra, rb, rs, 1'b1), 1'b0);
    end
    for (int i = 0; i < 50; i++) begin
      ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255)); rs = 1'($urandom);
      run_op(1'b0, ra, rb, rs, ref_mul(ra, rb, rs, 1'b0), 1'b0);
    end

    guard = 0;
    while ((q8.size() != 0 || q16.size() != 0) && guard < 100) begin
      @(posedge Clk);
      guard++;
    end
    check("scoreboard_drained", {16'(q8.size()), 16'(q16.size())}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
